// File: rtl/load_issue_queue.sv
// ============================================================================
// load_issue_queue : in-order FIFO between AGU load output and load selector.
// Optional zero-latency bypass: LOAD_ISSUE_QUEUE_BYPASS_EN.   Rev 1.0
// ============================================================================
`default_nettype none

package load_issue_queue_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        signExtend;
    logic [1:0]  size;
    logic [6:0]  tagDst;
    logic [6:0]  sqN;
    logic        doNotCommit;
    logic        exception;
    logic        isMMIO;
    logic        valid;
  } LD_UOp;
endpackage

module load_issue_queue
  import load_issue_queue_pkg::*;
#(
  parameter int NUM_ENTRIES = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  IN_flush,
  input  LD_UOp IN_uop,
  output logic  OUT_stall,
  output LD_UOp OUT_uop,
  input  logic  IN_stall
);

  localparam int PTR_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_ENTRIES);

  LD_UOp            slots_q [NUM_ENTRIES];
  LD_UOp            slots_d [NUM_ENTRIES];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic empty;
  logic full;
  logic bypass;
  logic enq;
  logic deq;

  always_comb begin
    empty  = (count_q == '0);
    full   = (count_q == CNT_FULL);
    bypass = 1'b0;
`ifdef LOAD_ISSUE_QUEUE_BYPASS_EN
    bypass = empty && IN_uop.valid && !IN_flush && !rst;
`endif

    OUT_stall     = full;
    OUT_uop       = slots_q[head_q];
    OUT_uop.valid = !empty && !IN_flush && !rst;
`ifdef LOAD_ISSUE_QUEUE_BYPASS_EN
    if (bypass) begin
      OUT_uop = IN_uop;
    end
`endif

    // A bypassed uop that is consumed directly never touches storage.
    deq = !empty && !IN_flush && !IN_stall;
    enq = IN_uop.valid && !full && !IN_flush && !(bypass && !IN_stall);

    slots_d = slots_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, deq};

    if (enq) begin
      slots_d[tail_q] = IN_uop;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (deq) begin
      head_d = head_q + PTR_W'(1);
    end

    if (IN_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    slots_q <= slots_d;
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_issue_queue.sv
// ============================================================================
// tb_load_issue_queue : directed self-checking bench for load_issue_queue.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_load_issue_queue;
  import load_issue_queue_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  in_flush;
  logic  in_stall;
  LD_UOp in_uop;
  LD_UOp out_uop;
  logic  out_stall;

  int errors = 0;
  int checks = 0;

  LD_UOp none;
  LD_UOp u1;
  LD_UOp a [5];
  LD_UOp s [8];
  LD_UOp f [4];
  LD_UOp r [3];
  LD_UOp g;

  load_issue_queue #(.NUM_ENTRIES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .IN_flush  (in_flush),
    .IN_uop    (in_uop),
    .OUT_stall (out_stall),
    .OUT_uop   (out_uop),
    .IN_stall  (in_stall)
  );

  always #5 clk = ~clk;

  function automatic LD_UOp mk(input logic [31:0] ad, input logic [6:0] tg, input logic [6:0] sq);
    LD_UOp u;
    u.addr        = ad;
    u.signExtend  = tg[0];
    u.size        = sq[1:0];
    u.tagDst      = tg;
    u.sqN         = sq;
    u.doNotCommit = ad[4];
    u.exception   = ad[5];
    u.isMMIO      = tg[1];
    u.valid       = 1'b1;
    return u;
  endfunction

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic drive(input LD_UOp u, input logic st, input logic fl, input logic rs);
    @(posedge clk);
    #1;
    in_uop   = u;
    in_stall = st;
    in_flush = fl;
    rst      = rs;
    #1;
  endtask

  task automatic chk_stall(input string name, input logic exp);
    checks++;
    assert (out_stall === exp) else begin
      errors++;
      $error("FAIL %s: OUT_stall observed=%0b expected=%0b", name, out_stall, exp);
    end
  endtask

  task automatic chk_uop(input string name, input LD_UOp exp);
    checks++;
    if (exp.valid) begin
      assert (out_uop === exp) else begin
        errors++;
        $error("FAIL %s: OUT_uop observed=%h expected=%h", name, out_uop, exp);
      end
    end else begin
      assert (out_uop.valid === 1'b0) else begin
        errors++;
        $error("FAIL %s: OUT_uop.valid observed=%0b expected=0", name, out_uop.valid);
      end
    end
  endtask

  initial begin
    none = '0;
    u1   = mk(32'h0000_1000, 7'd5, 7'd3);
    for (int i = 0; i < 5; i++) a[i] = mk(32'h2000 + 32'(i * 16), 7'(10 + i), 7'(20 + i));
    for (int i = 0; i < 8; i++) s[i] = mk(32'h3000 + 32'(i * 48), 7'(40 + i), 7'(60 + i));
    for (int i = 0; i < 4; i++) f[i] = mk(32'h4000 + 32'(i * 32), 7'(70 + i), 7'(80 + i));
    for (int i = 0; i < 3; i++) r[i] = mk(32'h5000 + 32'(i * 16), 7'(90 + i), 7'(100 + i));
    g = mk(32'h6030, 7'd3, 7'd1);

    rst = 1'b1; in_flush = 1'b0; in_stall = 1'b0; in_uop = none;
    repeat (2) @(posedge clk);

    // Reset state
    drive(none, 1'b0, 1'b0, 1'b0);
    chk_stall("reset_stall", 1'b0);
    chk_uop("reset_valid", none);

    // Single uop: one cycle of latency, visible for one cycle
    drive(u1, 1'b0, 1'b0, 1'b0);
    chk_uop("single_same_cycle", none);
    drive(none, 1'b0, 1'b0, 1'b0);
    chk_uop("single_out", u1);
    drive(none, 1'b0, 1'b0, 1'b0);
    chk_uop("single_gone", none);

    // Fill under IN_stall: four accepted, head held stable
    for (int k = 0; k < 4; k++) begin
      drive(a[k], 1'b1, 1'b0, 1'b0);
      chk_stall($sformatf("fill_stall_%0d", k), 1'b0);
      chk_uop($sformatf("fill_head_%0d", k), (k == 0) ? none : a[0]);
    end
    drive(a[4], 1'b1, 1'b0, 1'b0);
    chk_stall("full_stall_0", 1'b1);
    chk_uop("full_head_0", a[0]);
    drive(a[4], 1'b1, 1'b0, 1'b0);
    chk_stall("full_stall_1", 1'b1);
    chk_uop("full_head_1", a[0]);

    // Release: full refuses a5 despite the dequeue, then drains 1..5 in order
    drive(a[4], 1'b0, 1'b0, 1'b0);
    chk_stall("drain_stall_full", 1'b1);
    chk_uop("drain_0", a[0]);
    drive(a[4], 1'b0, 1'b0, 1'b0);
    chk_stall("drain_stall_fell", 1'b0);
    chk_uop("drain_1", a[1]);
    drive(none, 1'b0, 1'b0, 1'b0);
    chk_uop("drain_2", a[2]);
    drive(none, 1'b0, 1'b0, 1'b0);
    chk_uop("drain_3", a[3]);
    drive(none, 1'b0, 1'b0, 1'b0);
    chk_uop("drain_4_wrap", a[4]);
    drive(none, 1'b0, 1'b0, 1'b0);
    chk_uop("drain_empty", none);

    // Continuous stream: one per cycle, no bubbles, never stalls
    for (int k = 0; k < 8; k++) begin
      drive(s[k], 1'b0, 1'b0, 1'b0);
      chk_stall($sformatf("stream_stall_%0d", k), 1'b0);
      chk_uop($sformatf("stream_out_%0d", k), (k == 0) ? none : s[k-1]);
    end
    drive(none, 1'b0, 1'b0, 1'b0);
    chk_uop("stream_last", s[7]);
    drive(none, 1'b0, 1'b0, 1'b0);
    chk_uop("stream_empty", none);

    // Flush with three buffered and a valid incoming uop
    for (int k = 0; k < 3; k++) drive(f[k], 1'b1, 1'b0, 1'b0);
    chk_uop("flush_pre_head", f[0]);
    drive(f[3], 1'b1, 1'b1, 1'b0);
    chk_uop("flush_cycle_valid", none);
    drive(none, 1'b0, 1'b0, 1'b0);
    chk_uop("flush_after_0", none);
    chk_stall("flush_after_stall", 1'b0);
    drive(none, 1'b0, 1'b0, 1'b0);
    chk_uop("flush_after_1", none);

    // Reset mid-operation with two buffered
    drive(r[0], 1'b1, 1'b0, 1'b0);
    drive(r[1], 1'b1, 1'b0, 1'b0);
    chk_uop("rst_pre_head", r[0]);
    drive(r[2], 1'b0, 1'b0, 1'b1);
    drive(none, 1'b0, 1'b0, 1'b0);
    chk_uop("rst_after_0", none);
    chk_stall("rst_after_stall", 1'b0);
    drive(none, 1'b0, 1'b0, 1'b0);
    chk_uop("rst_after_1", none);

    // Queue still usable after reset
    drive(g, 1'b0, 1'b0, 1'b0);
    chk_uop("post_rst_same", none);
    drive(none, 1'b0, 1'b0, 1'b0);
    chk_uop("post_rst_out", g);
    drive(none, 1'b0, 1'b0, 1'b0);
    chk_uop("post_rst_empty", none);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_issue_queue.md
# load_issue_queue

Small FIFO between the AGU load output and the load selector that arbitrates AGU loads against page-walker loads. AGU load uops are buffered here while the selector stalls them, whether the load pipeline is busy or the arbitration result goes against them. Buffered uops are released in program order. The queue decouples the AGU from selector backpressure and drops all buffered uops on a pipeline flush.

## Interface
Parameters:
- NUM_ENTRIES, default 4: queue depth. Must be a power of two and at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- IN_flush  input  1  synchronous kill of all buffered and incoming uops.
- IN_uop  input  LD_UOp  load uop from the AGU. Qualified by IN_uop.valid.
- OUT_stall  output  1  to the AGU: the uop on IN_uop is not accepted this cycle.
- OUT_uop  output  LD_UOp  head uop to the load selector's AGU input.
- IN_stall  input  1  from the load selector (its AGU-load stall): OUT_uop is not consumed this cycle.

## Operation
- Storage:
  - NUM_ENTRIES slots of LD_UOp.
  - Head and tail pointers, each log2(NUM_ENTRIES) bits, wrapping modulo NUM_ENTRIES.
  - count, log2(NUM_ENTRIES)+1 bits, range 0..NUM_ENTRIES.
- Enqueue condition: IN_uop.valid && !OUT_stall && !IN_flush.
  - Writes slot[tail].
  - tail increments.
- Dequeue condition: OUT_uop.valid && !IN_stall.
  - head increments.
  - The payload is not cleared.
- count update: count_next = count + enq - deq.
  - Simultaneous enqueue and dequeue leaves count unchanged.
- OUT_stall = (count == NUM_ENTRIES).
  - Depends only on registered state. No combinational path from IN_stall or IN_uop.
  - When full, an enqueue is refused even if a dequeue happens in the same cycle.
- OUT_uop when count > 0 and !IN_flush:
  - OUT_uop = slot[head] with valid=1.
- OUT_uop when count == 0 or IN_flush:
  - OUT_uop.valid = 0; all other fields are don't-care (X allowed).
- Payload fields pass through unmodified in FIFO order: addr, signExtend, size, tagDst, sqN, doNotCommit, exception, isMMIO.
  - The queue never reorders, merges or drops uops, except on flush.
- Flush (IN_flush=1):
  - Next cycle: head = tail = 0 and count = 0.
  - No enqueue or dequeue takes effect in the flush cycle.
  - OUT_uop.valid = 0 in the flush cycle.
- Reset (rst=1): identical to flush.
  - Applies regardless of other inputs, including mid-operation.
- A uop accepted in the last cycle before a flush is discarded with the rest.

## Timing
- Reset state:
  - head = tail = 0, count = 0.
  - OUT_stall = 0.
  - OUT_uop.valid = 0.
- Latency without bypass: a uop enqueued in cycle N appears on OUT_uop in cycle N+1 at the earliest.
- Throughput: one enqueue and one dequeue per cycle.
- Full queue: OUT_stall is high in every cycle with count == NUM_ENTRIES. It falls the cycle after the first dequeue.
- Empty queue: OUT_uop.valid is low in every cycle with count == 0, unless bypass applies (see Configuration).
- IN_stall held high: the OUT_uop payload is held stable cycle to cycle and head does not move.

## Configuration
- Macro: LOAD_ISSUE_QUEUE_BYPASS_EN.
- Defined: a zero-latency bypass is active when count == 0, IN_uop.valid = 1 and IN_flush = 0.
  - OUT_uop = IN_uop combinationally.
  - If IN_stall = 0, the uop is consumed directly. It is not written, and no pointer or count moves.
  - If IN_stall = 1, the uop is enqueued normally.
  - This adds a combinational path IN_uop -> OUT_uop.
- Undefined: no bypass. All uops take at least one cycle through storage, and OUT_uop is driven purely from registers.

## Test plan
- Reset, then a single uop (addr=0x1000, tagDst=5, sqN=3), IN_stall=0:
  - Without bypass: OUT_uop.valid=1 with identical fields exactly one cycle later, for one cycle.
  - With bypass: the same uop appears in the same cycle, and count stays 0.
- IN_stall held high, 5 uops offered back-to-back (NUM_ENTRIES=4):
  - 4 are accepted.
  - OUT_stall=1 from the cycle after the 4th accept.
  - The 5th uop is held by the AGU.
  - OUT_uop holds uop#1 stable throughout.
- Release IN_stall with a full queue and the AGU continuously valid:
  - Uops drain in order 1..5 at one per cycle.
  - OUT_stall falls one cycle after the first dequeue.
  - The wrap-around of head and tail is exercised.
- Continuous stream of 8 uops, IN_stall=0:
  - One dequeue per cycle.
  - count is never above 1.
  - No bubbles after the first output.
- 3 uops buffered, IN_flush asserted together with a valid IN_uop:
  - OUT_uop.valid=0 in the flush cycle.
  - count=0 in the next cycle.
  - The flush-cycle uop is never output.
- rst asserted with 2 uops buffered and IN_stall=0:
  - Next cycle: OUT_uop.valid=0, OUT_stall=0.
  - No stale uop is ever emitted afterwards.
